// File: rtl/gmul_pkg.sv
// Shared definitions for the gmul family: fold FSM states, length width and
// the GF(2) multiply-by-x step.
package gmul_pkg;

   localparam int LEN_W     = 16;
   localparam int MUL_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } fold_state_e;

   // a*x mod (x^w + m); only the low w bits of a and m are meaningful
   function automatic logic [MUL_MAX_W-1:0] mul2(input logic [MUL_MAX_W-1:0] a,
                                                 input logic [MUL_MAX_W-1:0] m,
                                                 input int                   w);
      logic [MUL_MAX_W-1:0] mask;
      logic                 msb;
      mask = '0;
      for (int i = 0; i < MUL_MAX_W; i++) mask[i] = (i < w);
      msb = a[w-1];
      return ((a << 1) ^ (msb ? m : '0)) & mask;
   endfunction

endpackage

// File: rtl/mul256.sv
// Combinational multiply by x^8 in GF(2^DWIDTH), modulus x^DWIDTH + m.
module mul256
   import gmul_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic [DWIDTH-1:0] i_a,
   input  logic [DWIDTH-1:0] i_m,
   output logic [DWIDTH-1:0] o_p
);

   logic [MUL_MAX_W-1:0] w_t;

   always_comb begin
      w_t = MUL_MAX_W'(i_a);
      for (int i = 0; i < 8; i++) w_t = mul2(w_t, MUL_MAX_W'(i_m), DWIDTH);
      o_p = w_t[DWIDTH-1:0];
   end

endmodule

// File: rtl/gf_poly_fold.sv
// Framed byte-stream fold: state <- (state*x^8 mod m) ^ byte, residue out
// through a valid/ready handshake with saturating byte count.
//
// state | meaning
// IDLE  | waiting for a first beat; non-first beats are dropped with err
// ACC   | mid-message, folding one byte per accepted beat
// HOLD  | residue presented on out_*, input stalled until out_ready
module gf_poly_fold
   import gmul_pkg::*;
#(
   parameter int                DWIDTH = 8,
   parameter logic [DWIDTH-1:0] INIT   = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DWIDTH-1:0] i_cfg_m,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [7:0]        i_in_data,
   input  logic              i_in_first,
   input  logic              i_in_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DWIDTH-1:0] o_out_res,
   output logic [LEN_W-1:0]  o_out_len,
   output logic              o_err
);

   fold_state_e       r_state;
   logic [DWIDTH-1:0] r_acc;
   logic [DWIDTH-1:0] r_mq;
   logic [LEN_W-1:0]  r_len;
   logic              r_err;

   logic              w_first;
   logic [DWIDTH-1:0] w_a;
   logic [DWIDTH-1:0] w_m;
   logic [DWIDTH-1:0] w_p;
   logic [DWIDTH-1:0] w_fold;

   // A first beat restarts from INIT under the incoming modulus
   assign w_first = i_in_first;
   assign w_a     = w_first ? INIT : r_acc;
   assign w_m     = w_first ? i_cfg_m : r_mq;
   assign w_fold  = w_p ^ DWIDTH'(i_in_data);

   mul256 #(.DWIDTH(DWIDTH)) u_mul256 (
      .i_a (w_a),
      .i_m (w_m),
      .o_p (w_p)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_mq    <= '0;
         r_len   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE, ACC: begin
               if (i_in_valid) begin
                  if (i_in_first) begin
                     r_err   <= (r_state == ACC);
                     r_mq    <= i_cfg_m;
                     r_acc   <= w_fold;
                     r_len   <= LEN_W'(1);
                     r_state <= i_in_last ? HOLD : ACC;
                  end else if (r_state == IDLE) begin
                     r_err <= 1'b1;
                  end else begin
                     r_acc <= w_fold;
                     r_len <= (r_len == '1) ? r_len : r_len + LEN_W'(1);
                     if (i_in_last) r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (i_out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready  = (r_state != HOLD);
   assign o_out_valid = (r_state == HOLD);
   assign o_out_res   = r_acc;
   assign o_out_len   = r_len;
   assign o_err       = r_err;

endmodule

// File: tb/tb_gf_poly_fold.sv
// Bench for gf_poly_fold: vector table, corner sequences and random messages
// against a polynomial long-division reference.
module tb_gf_poly_fold;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cfg_m;
   logic        in_valid, in_first, in_last, out_ready;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, err;
   logic [7:0]  out_res;
   logic [15:0] out_len;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gf_poly_fold #(.DWIDTH(8), .INIT(8'h00)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cfg_m     (cfg_m),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_first  (in_first),
      .i_in_last   (in_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_res   (out_res),
      .o_out_len   (out_len),
      .o_err       (err)
   );

   typedef struct {
      int         n;
      logic [7:0] d [4];
      logic [7:0] m;
      logic [7:0] exp_res;
   } vec_t;

   // Reference: (s * x^8) mod (x^8 + m) by long division, then add the byte
   function automatic logic [7:0] ref_fold(input logic [7:0] s, input logic [7:0] b,
                                           input logic [7:0] m);
      logic [15:0] v;
      logic [15:0] modp;
      v    = {s, 8'h00};
      modp = {7'b0, 1'b1, m};
      for (int i = 15; i >= 8; i--)
         if (v[i]) v = v ^ (modp << (i - 8));
      return v[7:0] ^ b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 8'h00;
   endtask

   task automatic beat(input logic [7:0] d, input logic f, input logic l);
      in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
      tick();
      idle_inputs();
   endtask

   // Sends a whole message, checks latency/result/length, then drains HOLD
   task automatic send_msg(input string name, input logic [7:0] q[$], input logic [7:0] m,
                           input logic [7:0] exp_res, input logic [15:0] exp_len,
                           input int stall);
      cfg_m = m;
      out_ready = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         check({name, "_in_ready"}, in_ready, 1'b1);
         beat(q[i], i == 0, i == q.size() - 1);
      end
      check({name, "_out_valid"}, out_valid, 1'b1);
      check({name, "_res"}, out_res, exp_res);
      check({name, "_len"}, out_len, exp_len);
      for (int i = 0; i < stall; i++) tick();
      if (stall > 0) check({name, "_res_stable"}, out_res, exp_res);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_drain"}, out_valid, 1'b0);
   endtask

   initial begin
      vec_t       vecs [6];
      logic [7:0] q[$];
      logic [7:0] s, m, d;
      int         n;

      vecs[0] = '{n: 1, d: '{8'h57, 8'h00, 8'h00, 8'h00}, m: 8'h1B, exp_res: 8'h57};
      vecs[1] = '{n: 2, d: '{8'h01, 8'h00, 8'h00, 8'h00}, m: 8'h1B, exp_res: 8'h1B};
      vecs[2] = '{n: 2, d: '{8'h02, 8'h00, 8'h00, 8'h00}, m: 8'h1B, exp_res: 8'h36};
      vecs[3] = '{n: 3, d: '{8'h01, 8'h00, 8'h00, 8'h00}, m: 8'h1B, exp_res: 8'h5E};
      vecs[4] = '{n: 2, d: '{8'h01, 8'h00, 8'h00, 8'h00}, m: 8'h1D, exp_res: 8'h1D};
      vecs[5] = '{n: 2, d: '{8'h01, 8'h07, 8'h00, 8'h00}, m: 8'h1B, exp_res: 8'h1C};

      rst = 1'b1; cfg_m = 8'h1B; out_ready = 1'b0;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_res", out_res, 8'h00);
      check("rst_len", out_len, 16'h0);
      check("rst_err", err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);

      foreach (vecs[k]) begin
         q.delete();
         for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].d[i]);
         send_msg($sformatf("vec%0d", k), q, vecs[k].m, vecs[k].exp_res,
                  16'(vecs[k].n), 0);
      end

      // HOLD stall with in_valid asserted: nothing must be consumed
      cfg_m = 8'h1B;
      beat(8'h01, 1'b1, 1'b0);
      beat(8'h00, 1'b0, 1'b1);
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", in_ready, 1'b0);
         tick();
      end
      check("hold_valid", out_valid, 1'b1);
      check("hold_res", out_res, 8'h1B);
      check("hold_len", out_len, 16'd2);
      check("hold_err", err, 1'b0);
      idle_inputs();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_release", out_valid, 1'b0);
      q = '{8'h57};
      send_msg("after_hold", q, 8'h1B, 8'h57, 16'd1, 0);

      // Stray beat in IDLE
      beat(8'h42, 1'b0, 1'b1);
      check("idle_err", err, 1'b1);
      check("idle_no_out", out_valid, 1'b0);
      tick();
      check("idle_err_one_cycle", err, 1'b0);

      // First beat mid-message abandons the old one
      beat(8'h33, 1'b1, 1'b0);
      beat(8'h44, 1'b0, 1'b0);
      check("mid_no_err", err, 1'b0);
      beat(8'h01, 1'b1, 1'b0);
      check("mid_first_err", err, 1'b1);
      beat(8'h00, 1'b0, 1'b1);
      check("mid_err_clear", err, 1'b0);
      check("mid_res", out_res, 8'h1B);
      check("mid_len", out_len, 16'd2);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Reset mid-message
      beat(8'hA1, 1'b1, 1'b0);
      beat(8'hB2, 1'b0, 1'b0);
      beat(8'hC3, 1'b0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_len", out_len, 16'd0);
      check("midrst_res", out_res, 8'd0);
      tick();
      check("midrst_no_stale", out_valid, 1'b0);
      q = '{8'h05};
      send_msg("after_rst", q, 8'h1B, 8'h05, 16'd1, 0);

      // Modulus is latched on the first beat only
      cfg_m = 8'h1B;
      beat(8'h01, 1'b1, 1'b0);
      cfg_m = 8'h00;
      beat(8'h00, 1'b0, 1'b1);
      check("mlatch_res", out_res, 8'h1B);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Random messages against the reference
      for (int k = 0; k < 25; k++) begin
         n = $urandom_range(1, 6);
         m = 8'($urandom);
         s = 8'h00;
         q.delete();
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            s = ref_fold(s, d, m);
         end
         send_msg($sformatf("rnd%0d", k), q, m, s, 16'(n), $urandom_range(0, 3));
      end

      // Length saturation
      m = 8'h1B;
      cfg_m = m;
      s = 8'h00;
      for (int i = 0; i < 70000; i++) begin
         d = 8'($urandom);
         s = ref_fold(s, d, m);
         beat(d, i == 0, i == 69999);
      end
      check("sat_valid", out_valid, 1'b1);
      check("sat_len", out_len, 16'hFFFF);
      check("sat_res", out_res, s);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gf_poly_fold.md
# gf_poly_fold

Streaming GF(2^DWIDTH) polynomial-residue accumulator for the gmul pipeline. It accepts a framed byte stream and folds each byte into a running state: state ← (state·x^8 mod m) ⊕ byte. It returns the final residue with a valid/ready handshake. This is the consumer stage that wraps the combinational x^8 multiplier `mul256` and uses it for CRC-style and hash-style reductions with a per-message modulus.

## Interface
- `DWIDTH`, default 8: field width and state width; must be ≥ 8.
- `INIT`, default `'0`: state seed applied before the first byte of each message.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_m`  in  DWIDTH: reduction polynomial without its x^DWIDTH term; sampled only on an accepted first beat.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block accepts a beat this cycle.
- `in_data`  in  8: message byte, zero-extended to DWIDTH.
- `in_first`  in  1: beat starts a message.
- `in_last`  in  1: beat ends a message; `in_first` and `in_last` may both be set.
- `out_valid`  out  1: residue available.
- `out_ready`  in  1: consumer takes the residue.
- `out_res`  out  DWIDTH: final residue.
- `out_len`  out  16: bytes in the message, saturating at 0xFFFF.
- `err`  out  1: one-cycle pulse on a framing violation.

## Operation
- A beat is accepted when `in_valid & in_ready`. `in_ready` is 1 in IDLE and ACC and 0 in HOLD.
- The fold step is fold(s, b) = mul256(s, m_q) ⊕ zext(b). `m_q` is the latched modulus.
- FSM states are IDLE, ACC and HOLD.
- IDLE, beat with `in_first`:
  - latch `m_q` ← `cfg_m`; set state ← fold(INIT, data); set len ← 1.
  - Go to HOLD if `in_last`, otherwise go to ACC.
- IDLE, beat without `in_first`: the beat is consumed and discarded, `err` pulses, and the FSM stays in IDLE.
- ACC, beat without `in_first`: state ← fold(state, data); len ← sat(len+1). Go to HOLD if `in_last`.
- ACC, beat with `in_first`: the current message is abandoned and `err` pulses. The beat is then handled exactly as an IDLE first beat, including the `m_q` re-latch.
- HOLD:
  - `out_valid`=1, with `out_res`=state and `out_len`=len held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored and no beat is consumed.
- Arithmetic:
  - All fold arithmetic is XOR/shift in GF(2); there are no carries.
  - `len` is 16 bits and saturates, so 0xFFFF + 1 = 0xFFFF.
- Reset:
  - FSM → IDLE; state, `m_q` and len → 0; `out_valid`, `err` → 0. `out_res` and `out_len` therefore read 0.
  - A reset mid-message or during HOLD discards everything, and no residue is emitted.

## Timing
- Throughput is one byte per cycle within a message.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted.
- There is at least one bubble between messages: the HOLD cycle(s), plus the return to IDLE.
- `out_res` and `out_len` are registered and stable while `out_valid` is 1 and `out_ready` is 0.
- `err` is registered and asserted for exactly the cycle after the offending beat.
- `cfg_m` changes during a message have no effect until the next accepted first beat.

## Structure
- Package `gmul_pkg` holds:
  - the `fold_state_e` enum (IDLE, ACC, HOLD);
  - the `LEN_W = 16` localparam;
  - the shared `mul2` function, reused across gmul blocks.
- Exactly one sub-module: `mul256 #(.DWIDTH(DWIDTH))`, instantiated with `a`=state (or INIT on a first beat), `m`=`m_q`, and its output `p` used as the fold product.
- On a first beat, the mux before `mul256` selects INIT and the `m` input selects `cfg_m`.

## Test plan
All scenarios use DWIDTH=8, INIT=0 and m=0x1B unless stated.
- Single beat 0x57 with first and last set → `out_res`=0x57, `out_len`=1, `out_valid` rises one cycle after acceptance.
- Beats {0x01 first, 0x00 last} → `out_res`=0x1B, `out_len`=2; {0x02 first, 0x00 last} → 0x36.
- Hold `out_ready`=0 for 5 cycles in HOLD with `in_valid`=1 → `in_ready`=0, outputs stable, no beat consumed; then `out_ready`=1 → IDLE and the next first beat is accepted.
- Beat without `in_first` in IDLE → `err` pulses one cycle, no output. Later, `in_first` arriving mid-message → `err` pulse, and a new message {0x01 first, 0x00 last} then yields 0x1B.
- Assert `rst` mid-message after 3 beats, then send {0x05 first+last} → `out_res`=0x05, `out_len`=1, and no stale output appears.
- Change `cfg_m` to 0x00 mid-message {0x01, 0x00} → result is still 0x1B. Send 70000 beats → `out_len`=0xFFFF.
